uart_cmd_asm: RTL

Command assembler sitting directly downstream of the UART receiver. Consumes received bytes over the receiver's `rdy`/`clr_rdy` handshake and packs two consecutive bytes (high byte first) into a 16-bit command for the balance-control command decoder. Includes an inter-byte timeout that resynchronises framing after a lost byte, and a sticky overrun flag.

---
 rtl/uart_cmd_asm.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_cmd_asm.sv
// uart_cmd_asm: packs two received UART bytes (high byte first) into a 16-bit
// command, with a sticky overrun flag. Define UART_CMD_TIMEOUT_EN to enable the
// inter-byte timeout that drops a lone high byte after TIMEOUT_CYCLES clocks.
module uart_cmd_asm #(
   parameter int unsigned TIMEOUT_CYCLES = 52080
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_rdy,
   output logic        clr_rx_rdy,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   output logic        overrun
);

   typedef enum logic {S_HIGH = 1'b0, S_LOW = 1'b1} state_t;

   state_t      state, state_nxt;
   logic        armed, armed_nxt;
   logic [7:0]  hi_byte, hi_byte_nxt;
   logic [15:0] cmd_nxt;
   logic        cmd_rdy_nxt;
   logic        overrun_nxt;
   logic        clr_rx_rdy_nxt;
   logic        accept_c;
   logic        complete_c;
   logic        timeout_c;

   // Elaboration-time guard on the timeout range
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1048575) begin : g_bad_timeout
      $error("uart_cmd_asm: TIMEOUT_CYCLES out of range");
   end

`ifdef UART_CMD_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [CNT_W-1:0] cnt, cnt_nxt;

   // Inter-byte counter: cleared on high byte, saturating count while waiting in LOW
   always_comb begin
      cnt_nxt   = cnt;
      timeout_c = 1'b0;
      if (state == S_HIGH) begin
         if (accept_c) cnt_nxt = '0;
      end else if (!accept_c) begin
         if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
         timeout_c = (cnt_nxt == CNT_LAST);
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= cnt_nxt;
   end
`else
   assign timeout_c = 1'b0;
`endif

   // Accept each receiver byte once: re-arm only after rx_rdy has been seen low
   assign accept_c   = rx_rdy & armed;
   assign complete_c = (state == S_LOW) & accept_c;

   // Next-state and next-output logic
   always_comb begin
      state_nxt      = state;
      armed_nxt      = armed;
      hi_byte_nxt    = hi_byte;
      cmd_nxt        = cmd;
      cmd_rdy_nxt    = cmd_rdy;
      overrun_nxt    = overrun;
      clr_rx_rdy_nxt = accept_c;

      if (!rx_rdy)       armed_nxt = 1'b1;
      else if (accept_c) armed_nxt = 1'b0;

      case (state)
         S_HIGH: begin
            if (accept_c) begin
               hi_byte_nxt = rx_data;
               state_nxt   = S_LOW;
            end
         end
         S_LOW: begin
            if (accept_c) begin
               cmd_nxt   = {hi_byte, rx_data};
               state_nxt = S_HIGH;
            end else if (timeout_c) begin
               state_nxt = S_HIGH;
            end
         end
         default: state_nxt = S_HIGH;
      endcase

      // Completion wins over a simultaneous acknowledge
      if (complete_c)       cmd_rdy_nxt = 1'b1;
      else if (clr_cmd_rdy) cmd_rdy_nxt = 1'b0;

      if (complete_c && cmd_rdy && !clr_cmd_rdy) overrun_nxt = 1'b1;
      else if (clr_cmd_rdy)                      overrun_nxt = 1'b0;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_HIGH;
      else        state <= state_nxt;
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed      <= 1'b1;
         hi_byte    <= 8'h00;
         cmd        <= 16'h0000;
         cmd_rdy    <= 1'b0;
         overrun    <= 1'b0;
         clr_rx_rdy <= 1'b0;
      end else begin
         armed      <= armed_nxt;
         hi_byte    <= hi_byte_nxt;
         cmd        <= cmd_nxt;
         cmd_rdy    <= cmd_rdy_nxt;
         overrun    <= overrun_nxt;
         clr_rx_rdy <= clr_rx_rdy_nxt;
      end
   end

endmodule
